// File: rtl/fpu_issue_if.sv
// fpu_issue_if: command, response and FPU-side signals of the FPU issue controller
//   slave  : the controller (takes cmd_*, rsp_ready, fpu_result/fpu_ready; drives the rest)
//   master : the environment (command source, response sink and FPU)
interface fpu_issue_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_error;
  logic [WIDTH-1:0] fpu_operand_1;
  logic [WIDTH-1:0] fpu_operand_2;
  logic [1:0]       fpu_operation;
  logic [WIDTH-1:0] fpu_result;
  logic             fpu_ready;
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, fpu_result, fpu_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error, fpu_operand_1, fpu_operand_2, fpu_operation
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, fpu_result, fpu_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_error, fpu_operand_1, fpu_operand_2, fpu_operation
  );
endinterface

// File: rtl/fpu_issue_controller.sv
// fpu_issue_controller: issues one command at a time to an external FPU and returns its result
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : fpu_issue_if.slave -- cmd_* command handshake, rsp_* response handshake, fpu_* FPU side
//   FPU_ISSUE_TIMEOUT_EN : when defined, WAIT gives up after TIMEOUT_CYCLES and responds
//                          with rsp_error=1, rsp_data=0; otherwise rsp_error is tied low
module fpu_issue_controller #(
  parameter int WIDTH          = 32,
  parameter int FBITS          = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic        clk,
  input logic        reset,
  fpu_issue_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
  state_t           state;
  logic             cmd_rdy;
  logic             rsp_vld;
  logic [1:0]       opc;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] data;
  logic             tmo;
  logic             fin;
  logic             unused_cfg;
  assign unused_cfg = (FBITS > 0) && (TIMEOUT_CYCLES > 0);
`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          err;
  assign tmo = state == WAIT && !bus.fpu_ready && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign bus.rsp_error = err;
`else
  assign tmo = 1'b0;
  assign bus.rsp_error = 1'b0;
`endif
  // ADD/SUB finish at the end of ISSUE; MUL/SQRT only on fpu_ready (or timeout) in WAIT
  assign fin = (state == ISSUE && !opc[1]) || (state == WAIT && (bus.fpu_ready || tmo));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      cmd_rdy <= 1'b1;
      rsp_vld <= 1'b0;
      data    <= '0;
      opc     <= '0;
      op1     <= '0;
      op2     <= '0;
`ifdef FPU_ISSUE_TIMEOUT_EN
      cnt     <= '0;
      err     <= 1'b0;
`endif
    end else begin
`ifdef FPU_ISSUE_TIMEOUT_EN
      cnt <= state == WAIT && !fin ? cnt + 1'b1 : '0;
      if (fin) err <= tmo;
`endif
      case (state)
        IDLE:
          if (bus.cmd_valid) begin
            state   <= ISSUE;
            cmd_rdy <= 1'b0;
            opc     <= bus.cmd_op;
            op1     <= bus.cmd_a;
            op2     <= bus.cmd_op == 2'b11 ? '0 : bus.cmd_b;
          end
        ISSUE, WAIT:
          if (fin) begin
            state   <= RESPOND;
            rsp_vld <= 1'b1;
            data    <= tmo ? '0 : bus.fpu_result;
            opc     <= '0;
            op1     <= '0;
            op2     <= '0;
          end else
            state <= WAIT;
        RESPOND:
          if (bus.rsp_ready) begin
            state   <= IDLE;
            rsp_vld <= 1'b0;
            cmd_rdy <= 1'b1;
          end
      endcase
    end
  assign bus.cmd_ready     = cmd_rdy;
  assign bus.rsp_valid     = rsp_vld;
  assign bus.rsp_data      = data;
  assign bus.fpu_operation = opc;
  assign bus.fpu_operand_1 = op1;
  assign bus.fpu_operand_2 = op2;
endmodule

// File: doc/fpu_issue_controller.md
FPU_ISSUE_CONTROLLER -- requirements
Module: fpu_issue_controller

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter FBITS, default 10, fraction bits; informational only, no arithmetic depends on it.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, maximum cycles waited for fpu_ready.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  controller accepts a command this cycle.
REQ-008 cmd_op  input  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 SQRT.
REQ-009 cmd_a, cmd_b  input  WIDTH  operands; cmd_b ignored for SQRT.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 rsp_data  output  WIDTH  FPU result.
REQ-013 rsp_error  output  1  transaction timed out.
REQ-014 fpu_operand_1, fpu_operand_2  output  WIDTH  operands driven to the FPU.
REQ-015 fpu_operation  output  2  opcode driven to the FPU.
REQ-016 fpu_result  input  WIDTH  FPU result.
REQ-017 fpu_ready  input  1  FPU completion for MUL/SQRT.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, RESPOND.
REQ-019 IDLE: cmd_ready=1; cmd_valid&cmd_ready captures op/a/b (b forced to 0 for SQRT) and moves to ISSUE; cmd_ready=0 in all other states.
REQ-020 ISSUE (exactly 1 cycle): drives captured values on fpu_* outputs; ADD/SUB -> RESPOND, sampling fpu_result at the end of this cycle; MUL/SQRT -> WAIT.
REQ-021 WAIT: fpu_* outputs held stable; fpu_ready=1 samples fpu_result and moves to RESPOND.
REQ-022 fpu_ready asserted during ISSUE for MUL/SQRT SHALL be ignored; only WAIT-state fpu_ready completes.
REQ-023 RESPOND: rsp_valid=1; rsp_data/rsp_error held stable until rsp_ready=1, then -> IDLE on the next edge.
REQ-024 ADD/SUB latency: rsp_valid rises 2 cycles after command acceptance; MUL/SQRT: 1 cycle after the fpu_ready sample.
REQ-025 Outside ISSUE/WAIT, fpu_operand_1/2 and fpu_operation SHALL be driven to 0, never X or Z.
REQ-026 Back-to-back commands: no new command is accepted in the RESPOND cycle in which rsp_ready is seen; the next accept is earliest in the following IDLE cycle.
REQ-027 rsp_data SHALL be passed through unmodified (no saturation or rounding).

Reset
REQ-028 reset low SHALL immediately force state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_error=0, fpu_* outputs 0, timeout counter 0.
REQ-029 reset mid-transaction SHALL abandon it without generating a response; a late fpu_ready after reset release is ignored in IDLE.

Configuration
REQ-030 Macro FPU_ISSUE_TIMEOUT_EN defined: a counter runs in WAIT; if TIMEOUT_CYCLES elapse without fpu_ready -> RESPOND with rsp_error=1 and rsp_data=0.
REQ-031 Macro undefined: no counter; WAIT lasts indefinitely; rsp_error is tied to 0.

Verification
REQ-032 ADD cmd_a=0x00000E80, cmd_b=0x00001040 -> fpu_operation=00 for 1 cycle, rsp_data=0x00001EC0, rsp_valid 2 cycles after accept.
REQ-033 SUB 0x00000E80 - 0x00000600 -> rsp_data=0x00000880, rsp_error=0.
REQ-034 MUL 0x00000E80 x 0x00000600 with FPU model asserting fpu_ready 5 cycles later -> operands held through WAIT, rsp_data=0x000015C0.
REQ-035 SQRT cmd_a=0x00010000, cmd_b=0xFFFFFFFF -> fpu_operand_2=0, rsp_data=0x00002000; rsp_ready held low 3 cycles -> rsp_data stable, cmd_ready=0.
REQ-036 With FPU_ISSUE_TIMEOUT_EN and fpu_ready never asserted -> rsp_error=1, rsp_data=0 after TIMEOUT_CYCLES; without the macro -> still in WAIT after 200 cycles.
REQ-037 reset pulsed low during WAIT -> all outputs at reset values in the same cycle; no response after release.
